// File: rtl/app_lock_controller.sv
// app_lock_controller
//   Sequencing controller for a 4-digit BCD PIN lock. Collects keypad digits into an
//   entry buffer, checks them against the stored PIN, holds a timed unlock window,
//   counts consecutive failures with a timed lockout, and allows a PIN change while
//   unlocked. All outputs are registered.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-low reset
//   i_key_valid    one-cycle strobe, i_key_digit valid
//   i_key_digit    BCD digit 0..9
//   i_key_enter    one-cycle strobe, submit entry
//   i_key_clear    one-cycle strobe, discard entry / relock
//   i_change_req   one-cycle strobe, begin PIN change (unlocked only)
//   o_unlocked     access granted
//   o_locked_out   lockout active
//   o_error        one-cycle pulse on a rejected action or failed check
//   o_pin_changed  one-cycle pulse when a new PIN is committed
//   o_fail_count   consecutive failure count
//   o_state        FSM state: IDLE=0 ENTRY=1 CHECK=2 UNLOCKED=3 NEWPIN=4 LOCKOUT=5
module app_lock_controller #(
    parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned UNLOCK_CYCLES  = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_digit,
    input  logic       i_key_enter,
    input  logic       i_key_clear,
    input  logic       i_change_req,
    output logic       o_unlocked,
    output logic       o_locked_out,
    output logic       o_error,
    output logic       o_pin_changed,
    output logic [2:0] o_fail_count,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StEntry    = 3'd1,
        StCheck    = 3'd2,
        StUnlocked = 3'd3,
        StNewpin   = 3'd4,
        StLockout  = 3'd5
    } state_t;

    localparam logic [7:0] UNLOCK_LOAD  = 8'(UNLOCK_CYCLES - 1);
    localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] MAX_FAIL     = 3'(MAX_ATTEMPTS);

    state_t      r_state;
    logic [15:0] r_pin;
    logic [15:0] r_buf;
    logic [2:0]  r_count;
    logic [2:0]  r_fail;
    logic [7:0]  r_timer;
    logic        r_unlocked;
    logic        r_locked_out;
    logic        r_error;
    logic        r_pin_changed;

    state_t      w_state_d;
    logic [15:0] w_pin_d;
    logic [15:0] w_buf_d;
    logic [2:0]  w_count_d;
    logic [2:0]  w_fail_d;
    logic [7:0]  w_timer_d;
    logic        w_err_evt;
    logic        w_commit_evt;
    logic        w_digit_ok;
    logic        w_unlocked_d;
    logic        w_locked_out_d;
    logic        w_error_d;
    logic        w_pin_changed_d;

    // A digit is accepted only if it is BCD and the buffer is not yet full.
    assign w_digit_ok = (i_key_digit <= 4'd9) && (r_count != 3'd4);

    // State register (also holds the datapath and registered outputs).
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= StIdle;
            r_pin         <= DEFAULT_PIN;
            r_buf         <= 16'h0000;
            r_count       <= 3'd0;
            r_fail        <= 3'd0;
            r_timer       <= 8'd0;
            r_unlocked    <= 1'b0;
            r_locked_out  <= 1'b0;
            r_error       <= 1'b0;
            r_pin_changed <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pin         <= w_pin_d;
            r_buf         <= w_buf_d;
            r_count       <= w_count_d;
            r_fail        <= w_fail_d;
            r_timer       <= w_timer_d;
            r_unlocked    <= w_unlocked_d;
            r_locked_out  <= w_locked_out_d;
            r_error       <= w_error_d;
            r_pin_changed <= w_pin_changed_d;
        end
    end

    // Next-state and datapath. Strobe priority: clear > enter > change > digit.
    always_comb begin
        w_state_d    = r_state;
        w_pin_d      = r_pin;
        w_buf_d      = r_buf;
        w_count_d    = r_count;
        w_fail_d     = r_fail;
        w_timer_d    = r_timer;
        w_err_evt    = 1'b0;
        w_commit_evt = 1'b0;

        case (r_state)
            StIdle, StEntry, StNewpin: begin
                if (i_key_clear) begin
                    if (r_state != StIdle) begin
                        w_buf_d   = 16'h0000;
                        w_count_d = 3'd0;
                    end
                    if (r_state == StEntry) w_state_d = StIdle;
                end else if (i_key_enter) begin
                    if (r_state == StIdle) begin
                        w_err_evt = 1'b1;
                    end else if (r_state == StEntry) begin
                        // Short entries are also judged in CHECK so they fail like a mismatch.
                        w_state_d = StCheck;
                    end else begin
                        if (r_count == 3'd4) begin
                            w_pin_d      = r_buf;
                            w_commit_evt = 1'b1;
                        end else begin
                            w_err_evt = 1'b1;
                        end
                        w_buf_d   = 16'h0000;
                        w_count_d = 3'd0;
                        w_state_d = StIdle;
                    end
                end else if (i_key_valid && !i_change_req) begin
                    if (w_digit_ok) begin
                        w_buf_d   = {r_buf[11:0], i_key_digit};
                        w_count_d = r_count + 3'd1;
                        if (r_state == StIdle) w_state_d = StEntry;
                    end else begin
                        w_err_evt = 1'b1;
                    end
                end
            end
            StCheck: begin
                w_buf_d   = 16'h0000;
                w_count_d = 3'd0;
                if ((r_count == 3'd4) && (r_buf == r_pin)) begin
                    w_state_d = StUnlocked;
                    w_fail_d  = 3'd0;
                    w_timer_d = UNLOCK_LOAD;
                end else begin
                    w_fail_d  = r_fail + 3'd1;
                    w_err_evt = 1'b1;
                    if (w_fail_d == MAX_FAIL) begin
                        w_state_d = StLockout;
                        w_timer_d = LOCKOUT_LOAD;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StUnlocked: begin
                if (i_key_clear) begin
                    w_state_d = StIdle;
                end else if (!i_key_enter && i_change_req) begin
                    w_state_d = StNewpin;
                    w_buf_d   = 16'h0000;
                    w_count_d = 3'd0;
                end else if (r_timer == 8'd0) begin
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer - 8'd1;
                end
            end
            StLockout: begin
                if (r_timer == 8'd0) begin
                    w_fail_d  = 3'd0;
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer - 8'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        w_unlocked_d    = (w_state_d == StUnlocked);
        w_locked_out_d  = (w_state_d == StLockout);
        w_error_d       = w_err_evt;
        w_pin_changed_d = w_commit_evt;
    end

    assign o_unlocked    = r_unlocked;
    assign o_locked_out  = r_locked_out;
    assign o_error       = r_error;
    assign o_pin_changed = r_pin_changed;
    assign o_fail_count  = r_fail;
    assign o_state       = r_state;

endmodule

// File: tb/tb_app_lock_controller.sv
// tb_app_lock_controller
//   Directed scenarios followed by a randomized phase; every cycle the DUT outputs are
//   compared against a transaction-level reference model of the lock (digit queue,
//   PIN array, remaining-cycle counters).
module tb_app_lock_controller;

    localparam int UNLOCK_N  = 8;
    localparam int LOCKOUT_N = 16;
    localparam int MAX_FAILS = 3;

    localparam int M_IDLE     = 0;
    localparam int M_ENTRY    = 1;
    localparam int M_CHECK    = 2;
    localparam int M_UNLOCKED = 3;
    localparam int M_NEWPIN   = 4;
    localparam int M_LOCKOUT  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic       change_req = 1'b0;
    logic       unlocked;
    logic       locked_out;
    logic       error;
    logic       pin_changed;
    logic [2:0] fail_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_mode;
    int m_fails;
    int m_left;
    int m_digits[$];
    int m_pin[4];
    int m_err;
    int m_chg;

    app_lock_controller #(
        .DEFAULT_PIN   (16'h1234),
        .MAX_ATTEMPTS  (MAX_FAILS),
        .UNLOCK_CYCLES (UNLOCK_N),
        .LOCKOUT_CYCLES(LOCKOUT_N)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_key_valid  (key_valid),
        .i_key_digit  (key_digit),
        .i_key_enter  (key_enter),
        .i_key_clear  (key_clear),
        .i_change_req (change_req),
        .o_unlocked   (unlocked),
        .o_locked_out (locked_out),
        .o_error      (error),
        .o_pin_changed(pin_changed),
        .o_fail_count (fail_count),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the lock's behaviour, applied to the strobes seen at this edge.
    task automatic model_step(input bit r, input bit v, input int d, input bit e,
                              input bit c, input bit ch);
        bit ok;
        m_err = 0;
        m_chg = 0;
        if (!r) begin
            m_mode = M_IDLE;
            m_digits.delete();
            m_pin = '{1, 2, 3, 4};
            m_fails = 0;
            m_left = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_ENTRY, M_NEWPIN: begin
                    if (c) begin
                        if (m_mode != M_IDLE) m_digits.delete();
                        if (m_mode == M_ENTRY) m_mode = M_IDLE;
                    end else if (e) begin
                        if (m_mode == M_IDLE) m_err = 1;
                        else if (m_mode == M_ENTRY) m_mode = M_CHECK;
                        else begin
                            if (m_digits.size() == 4) begin
                                for (int i = 0; i < 4; i++) m_pin[i] = m_digits[i];
                                m_chg = 1;
                            end else begin
                                m_err = 1;
                            end
                            m_digits.delete();
                            m_mode = M_IDLE;
                        end
                    end else if (ch) begin
                        // change request outside UNLOCKED does nothing but still wins
                    end else if (v) begin
                        if (d > 9 || m_digits.size() == 4) m_err = 1;
                        else begin
                            m_digits.push_back(d);
                            if (m_mode == M_IDLE) m_mode = M_ENTRY;
                        end
                    end
                end
                M_CHECK: begin
                    ok = (m_digits.size() == 4);
                    for (int i = 0; i < 4; i++)
                        if (ok && m_digits[i] != m_pin[i]) ok = 0;
                    m_digits.delete();
                    if (ok) begin
                        m_fails = 0;
                        m_mode = M_UNLOCKED;
                        m_left = UNLOCK_N;
                    end else begin
                        m_fails++;
                        m_err = 1;
                        if (m_fails == MAX_FAILS) begin
                            m_mode = M_LOCKOUT;
                            m_left = LOCKOUT_N;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                M_UNLOCKED: begin
                    if (c) m_mode = M_IDLE;
                    else if (!e && ch) begin
                        m_mode = M_NEWPIN;
                        m_digits.delete();
                    end else begin
                        m_left--;
                        if (m_left == 0) m_mode = M_IDLE;
                    end
                end
                default: begin // lockout
                    m_left--;
                    if (m_left == 0) begin
                        m_fails = 0;
                        m_mode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("state", 32'(state), m_mode);
        check("unlocked", 32'(unlocked), (m_mode == M_UNLOCKED) ? 1 : 0);
        check("locked_out", 32'(locked_out), (m_mode == M_LOCKOUT) ? 1 : 0);
        check("error", 32'(error), m_err);
        check("pin_changed", 32'(pin_changed), m_chg);
        check("fail_count", 32'(fail_count), m_fails);
    endtask

    task automatic tick(input bit r, input bit v, input logic [3:0] d, input bit e,
                        input bit c, input bit ch);
        @(negedge clk);
        rst_n = r;
        key_valid = v;
        key_digit = d;
        key_enter = e;
        key_clear = c;
        change_req = ch;
        @(posedge clk);
        model_step(r, v, int'(d), e, c, ch);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 4'd0, 0, 0, 0);
    endtask

    task automatic key(input logic [3:0] d);
        tick(1, 1, d, 0, 0, 0);
    endtask

    task automatic enter();
        tick(1, 0, 4'd0, 1, 0, 0);
    endtask

    task automatic clr();
        tick(1, 0, 4'd0, 0, 1, 0);
    endtask

    task automatic do_reset();
        tick(0, 0, 4'd0, 0, 0, 0);
    endtask

    task automatic pin4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        int cnt_u;
        int cnt_e;
        int cnt_l;
        bit rv, rve, rc, rch, rr;
        logic [3:0] rd;

        do_reset();
        do_reset();
        check("reset_state", 32'(state), 0);

        // Correct PIN: unlock window length and no error
        pin4(1, 2, 3, 4);
        enter();
        cnt_u = 0;
        cnt_e = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (i == 0) check("unlock_latency", 32'(unlocked), 1);
            cnt_u += int'(unlocked);
            cnt_e += int'(error);
        end
        check("unlock_cycles", cnt_u, UNLOCK_N);
        check("unlock_no_error", cnt_e, 0);

        // Three wrong attempts -> lockout; correct PIN ignored during lockout
        for (int k = 1; k <= 3; k++) begin
            pin4(1, 2, 3, 5);
            enter();
            idle(1);
            check("wrong_error", 32'(error), 1);
            check("wrong_fail_count", 32'(fail_count), k);
        end
        cnt_l = int'(locked_out);
        for (int i = 0; i < 20; i++) begin
            case (i)
                1: key(1);
                2: key(2);
                3: key(3);
                4: key(4);
                5: enter();
                default: idle(1);
            endcase
            cnt_l += int'(locked_out);
        end
        check("lockout_cycles", cnt_l, LOCKOUT_N);
        check("lockout_fail_clear", 32'(fail_count), 0);
        pin4(1, 2, 3, 4);
        enter();
        idle(1);
        check("post_lockout_unlock", 32'(unlocked), 1);

        // PIN change
        tick(1, 0, 4'd0, 0, 0, 1);
        pin4(9, 8, 7, 6);
        enter();
        check("pin_changed_pulse", 32'(pin_changed), 1);
        idle(1);
        pin4(1, 2, 3, 4);
        enter();
        idle(1);
        check("old_pin_rejected", 32'(error), 1);
        pin4(9, 8, 7, 6);
        enter();
        idle(1);
        check("new_pin_unlocks", 32'(unlocked), 1);
        clr();

        // Reset restores default PIN
        do_reset();
        pin4(1, 2, 3, 4);
        enter();
        idle(1);
        check("default_pin_restored", 32'(unlocked), 1);
        clr();

        // Boundaries
        key(4'hA);
        check("non_bcd_error", 32'(error), 1);
        pin4(1, 2, 3, 4);
        key(5);
        check("fifth_digit_error", 32'(error), 1);
        enter();
        idle(1);
        check("buffer_kept_four", 32'(unlocked), 1);
        clr();
        key(1);
        key(2);
        enter();
        idle(1);
        check("short_entry_fail", 32'(fail_count), 1);
        pin4(1, 2, 3, 4);
        tick(1, 0, 4'd0, 1, 1, 0);
        idle(2);
        check("clear_beats_enter", 32'(unlocked), 0);
        pin4(1, 2, 3, 4);
        enter();
        idle(1);
        clr();

        // Resets mid-entry, during unlock, during lockout
        key(1);
        key(2);
        do_reset();
        pin4(1, 2, 3, 4);
        enter();
        idle(3);
        do_reset();
        check("reset_unlocked", 32'(unlocked), 0);
        for (int k = 0; k < 3; k++) begin
            pin4(0, 0, 0, 0);
            enter();
            idle(1);
        end
        idle(3);
        do_reset();
        check("reset_lockout", 32'(locked_out), 0);

        // Short NEWPIN entry
        pin4(1, 2, 3, 4);
        enter();
        idle(1);
        tick(1, 0, 4'd0, 0, 0, 1);
        key(5); key(5); key(5);
        enter();
        check("newpin_short_error", 32'(error), 1);
        pin4(1, 2, 3, 4);
        enter();
        idle(1);
        check("newpin_short_keeps_pin", 32'(unlocked), 1);
        clr();

        // Randomized phase, biased towards the current PIN so unlocks do occur
        for (int i = 0; i < 4000; i++) begin
            rr  = ($urandom_range(0, 299) != 0);
            rv  = ($urandom_range(0, 99) < 50);
            rve = ($urandom_range(0, 99) < 8);
            rc  = ($urandom_range(0, 99) < 4);
            rch = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 99) < 8) rd = 4'($urandom_range(10, 15));
            else if ($urandom_range(0, 1) == 1 && m_digits.size() < 4)
                rd = 4'(m_pin[m_digits.size()]);
            else rd = 4'($urandom_range(0, 9));
            tick(rr, rv, rd, rve, rc, rch);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
